seq_magnitude_compare: RTL and testbench

Parametrised, sequential successor to the 2-bit combinational magnitude comparator. The block compares two WIDTH-bit operands most-significant digit first, DIGIT bits per clock. It stops early on the first differing digit and reports greater / equal / less on the same F1/F2/F3 outputs as the combinational part. It adds a signed mode and a start/busy/done handshake, so it can sit on a shared operand bus in the lab datapath, behind the operand registers.

---
 rtl/seq_magnitude_compare.sv | 73 +++++++
 tb/tb_seq_magnitude_compare.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_compare.sv
// seq_magnitude_compare: MSB-first digit-serial magnitude compare; ports clk, rst, start, signed_mode, A, B -> busy, done, F1 (A>B), F2 (A==B), F3 (A<B)
module seq_magnitude_compare #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             F1,
  output logic             F2,
  output logic             F3
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0] f_q, f_d;
  logic [DIGIT-1:0] a_dig, b_dig;
  assign a_dig = a_q[WIDTH-1 -: DIGIT];
  assign b_dig = b_q[WIDTH-1 -: DIGIT];
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    idx_d = idx_q;
    f_d = f_q;
    if (state_q == SCAN) begin
      if (a_dig != b_dig || idx_q == '0) begin
        f_d = {a_dig > b_dig, a_dig == b_dig, a_dig < b_dig};
        state_d = DONE;
      end else begin
        idx_d = idx_q - 1'b1;
        a_d = a_q << DIGIT;
        b_d = b_q << DIGIT;
      end
    end else if (start) begin
      a_d = {A[WIDTH-1] ^ signed_mode, A[WIDTH-2:0]};
      b_d = {B[WIDTH-1] ^ signed_mode, B[WIDTH-2:0]};
      idx_d = IW'(NDIG - 1);
      f_d = '0;
      state_d = SCAN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx_q <= '0;
      f_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      idx_q <= idx_d;
      f_q <= f_d;
    end
  end
  assign busy = state_q == SCAN;
  assign done = state_q == DONE;
  assign F1 = f_q[2];
  assign F2 = f_q[1];
  assign F3 = f_q[0];
endmodule

// File: tb/tb_seq_magnitude_compare.sv
// tb_seq_magnitude_compare: scoreboard bench over DIGIT = 1, 2, 4, 8 instances of an 8-bit compare
module tb_seq_magnitude_compare;
  typedef struct {
    logic [2:0] flags;
    int lat;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  logic [3:0] start_v = 0;
  logic signed_mode = 0;
  logic [7:0] A = 0, B = 0;
  logic [3:0] busy, done, f1, f2, f3;
  exp_t sbq[4][$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : dut
    seq_magnitude_compare #(.WIDTH(8), .DIGIT(1 << g)) u (
      .clk(clk), .rst(rst), .start(start_v[g]), .signed_mode(signed_mode),
      .A(A), .B(B), .busy(busy[g]), .done(done[g]),
      .F1(f1[g]), .F2(f2[g]), .F3(f3[g])
    );
  end
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input int g, input logic [7:0] a, input logic [7:0] b, input logic sm);
    exp_t e;
    int va, vb, d, nd, msb;
    logic [7:0] diff;
    va = sm ? int'($signed(a)) : int'(a);
    vb = sm ? int'($signed(b)) : int'(b);
    e.flags = {va > vb, va == vb, va < vb};
    d = 1 << g;
    nd = 8 / d;
    diff = a ^ b;
    msb = -1;
    for (int i = 7; i >= 0; i--) if (msb < 0 && diff[i]) msb = i;
    e.lat = msb < 0 ? nd : nd - msb / d;
    return e;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : mon
    int cnt = 0;
    exp_t e;
    always @(negedge clk) begin
      if (rst) cnt = 0;
      else begin
        if (busy[g]) cnt++;
        if (done[g]) begin
          chk("onehot", $countones({f1[g], f2[g], f3[g]}), 1);
          chk("expected_done", int'(sbq[g].size() != 0), 1);
          if (sbq[g].size() != 0) begin
            e = sbq[g].pop_front();
            chk($sformatf("flags_d%0d", 1 << g), int'({f1[g], f2[g], f3[g]}), int'(e.flags));
            chk($sformatf("latency_d%0d", 1 << g), cnt, e.lat);
          end
          cnt = 0;
        end
      end
    end
  end
  task automatic do_start(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    A = a;
    B = b;
    signed_mode = sm;
    start_v = m;
    for (int g = 0; g < 4; g++) if (m[g]) sbq[g].push_back(model(g, a, b, sm));
    @(posedge clk);
    #1 start_v = 0;
    A = 8'($urandom);
    B = 8'($urandom);
    signed_mode = 1'($urandom);
  endtask
  task automatic wait_idle(input logic [3:0] m);
    bit ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (((busy | done) & m) == 0) ok = 1;
    end
    chk("idle_timeout", int'(ok), 1);
  endtask
  initial begin
    bit seen;
    logic [7:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) chk("reset_outputs", int'({busy[g], done[g], f1[g], f2[g], f3[g]}), 0);
    do_start(4'b0010, 8'hA5, 8'h3C, 0); wait_idle(4'b0010);
    do_start(4'b0010, 8'h5A, 8'h5A, 0); wait_idle(4'b0010);
    do_start(4'b0010, 8'h12, 8'h13, 0); wait_idle(4'b0010);
    do_start(4'b0010, 8'h80, 8'h01, 1); wait_idle(4'b0010);
    do_start(4'b0010, 8'h80, 8'h01, 0); wait_idle(4'b0010);
    @(negedge clk);
    chk("flags_hold_idle", int'({f1[1], f2[1], f3[1]}), 3'b100);
    do_start(4'b0010, 8'h12, 8'h13, 0);
    @(negedge clk);
    A = 8'hFF;
    B = 8'h00;
    start_v = 4'b0010;
    @(posedge clk);
    #1 start_v = 0;
    wait_idle(4'b0010);
    do_start(4'b0010, 8'h12, 8'h13, 0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done[1]) seen = 1;
    end
    chk("b2b_done_seen", int'(seen), 1);
    A = 8'hA5;
    B = 8'h3C;
    signed_mode = 0;
    start_v = 4'b0010;
    sbq[1].push_back(model(1, 8'hA5, 8'h3C, 0));
    @(posedge clk);
    #1 start_v = 0;
    chk("b2b_busy", int'(busy[1]), 1);
    chk("b2b_flags_cleared", int'({f1[1], f2[1], f3[1]}), 0);
    wait_idle(4'b0010);
    do_start(4'b0010, 8'h5A, 8'h5A, 0);
    @(posedge clk);
    #1 rst = 1;
    start_v = 4'b0010;
    A = 8'h00;
    B = 8'h01;
    for (int g = 0; g < 4; g++) sbq[g].delete();
    @(posedge clk);
    #1 rst = 0;
    start_v = 0;
    chk("rst_mid_scan_outputs", int'({busy[1], done[1], f1[1], f2[1], f3[1]}), 0);
    @(posedge clk);
    #1 chk("rst_start_ignored", int'({busy[1], done[1]}), 0);
    repeat (6) @(posedge clk);
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'd1 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      do_start(4'hF, a, b, 1'($urandom));
      wait_idle(4'hF);
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) chk("scoreboard_empty", sbq[g].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
